// File: rtl/ser_tx_if.sv
// Frame-transmitter signal bundle: control/buffer side (master) and serializer side (slave).
// Signal names match the ser_tx ports so a bench or wrapper can bind them one-to-one.
interface ser_tx_if #(
    parameter int NUM_CH = 8,
    parameter int WORD_W = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              START;
    logic [WORD_W-1:0] RD_DATA;
    logic              RD_EN;
    logic [CH_W-1:0]   RD_ADDR;
    logic              S_CLK;
    logic              S_FS;
    logic              S_DATA;
    logic              BUSY;
    logic              DONE;
    logic              ERROR;

    modport master (
        output START, RD_DATA,
        input  RD_EN, RD_ADDR, S_CLK, S_FS, S_DATA, BUSY, DONE, ERROR
    );

    modport slave (
        input  START, RD_DATA,
        output RD_EN, RD_ADDR, S_CLK, S_FS, S_DATA, BUSY, DONE, ERROR
    );
endinterface

// File: rtl/ser_tx.sv
// Multi-channel frame serializer: fetches NUM_CH words from a buffer and shifts them out
// MSB first with a generated bit clock and a frame sync on the first bit of channel 0.
module ser_tx #(
    parameter int  NUM_CH  = 8,
    parameter int  WORD_W  = 8,
    parameter int  CLK_DIV = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              START,
    input  logic [WORD_W-1:0] RD_DATA,
    output logic              RD_EN,
    output logic [CH_W-1:0]   RD_ADDR,
    output logic              S_CLK,
    output logic              S_FS,
    output logic              S_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, END} state_t;

    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [BIT_W-1:0]  r_bit, w_bit_nxt;
    logic [CH_W-1:0]   r_ch, w_ch_nxt;
    logic [WORD_W-1:0] r_shift, w_shift_nxt;
    logic [WORD_W-1:0] r_hold, w_load_word;
    logic              r_rd_d1;

    logic              r_rd_en, w_rd_en_nxt;
    logic [CH_W-1:0]   r_rd_addr, w_rd_addr_nxt;
    logic              r_s_clk, w_s_clk_nxt;
    logic              r_s_fs, w_s_fs_nxt;
    logic              r_s_data, w_s_data_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_error, w_error_nxt;
    logic              w_shifting, w_prefetch, w_word_end;

    assign w_word_end = (r_state == SHIFT) && (r_div == DIV_LAST) && (r_bit == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (START) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = LOAD;
            LOAD:    w_state_nxt = SHIFT;
            SHIFT:   if (w_word_end && (r_ch == CH_LAST)) w_state_nxt = END;
            END:     w_state_nxt = START ? FETCH : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Prefetched word arrives one cycle after RD_EN; it may land exactly on the word
    // boundary (CLK_DIV=2), so take it live in that cycle, otherwise from the hold register.
    assign w_load_word = r_rd_d1 ? RD_DATA : r_hold;

    always_comb begin
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
        w_ch_nxt    = '0;
        w_shift_nxt = '0;
        case (r_state)
            LOAD: w_shift_nxt = RD_DATA;
            SHIFT: begin
                w_div_nxt   = r_div + 1'b1;
                w_bit_nxt   = r_bit;
                w_ch_nxt    = r_ch;
                w_shift_nxt = r_shift;
                if (r_div == DIV_LAST) begin
                    w_div_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt = '0;
                        if (r_ch != CH_LAST) begin
                            w_ch_nxt    = r_ch + 1'b1;
                            w_shift_nxt = w_load_word;
                        end else begin
                            w_ch_nxt    = '0;
                            w_shift_nxt = '0;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift << 1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs are computed from the next state/counters so that every port is a flop.
    always_comb begin
        w_shifting    = (w_state_nxt == SHIFT);
        w_prefetch    = w_shifting && (w_bit_nxt == BIT_LAST) && (w_div_nxt == '0)
                        && (w_ch_nxt != CH_LAST);
        w_rd_en_nxt   = (w_state_nxt == FETCH) || w_prefetch;
        w_rd_addr_nxt = '0;
        if (w_prefetch)
            w_rd_addr_nxt = w_ch_nxt + 1'b1;
        else if (w_shifting || (w_state_nxt == LOAD))
            w_rd_addr_nxt = r_rd_addr;
        w_s_clk_nxt   = w_shifting && (w_div_nxt < DIV_HALF);
        w_s_data_nxt  = w_shifting && w_shift_nxt[WORD_W-1];
        w_s_fs_nxt    = w_shifting && (w_ch_nxt == '0) && (w_bit_nxt == '0);
        w_busy_nxt    = (w_state_nxt inside {FETCH, LOAD, SHIFT});
        w_done_nxt    = (w_state_nxt == END);
        w_error_nxt   = START && (r_state inside {FETCH, LOAD, SHIFT});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= '0;
            r_bit     <= '0;
            r_ch      <= '0;
            r_shift   <= '0;
            r_hold    <= '0;
            r_rd_d1   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_s_clk   <= 1'b0;
            r_s_fs    <= 1'b0;
            r_s_data  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_div     <= w_div_nxt;
            r_bit     <= w_bit_nxt;
            r_ch      <= w_ch_nxt;
            r_shift   <= w_shift_nxt;
            r_rd_d1   <= r_rd_en;
            if (r_rd_d1) r_hold <= RD_DATA;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_s_clk   <= w_s_clk_nxt;
            r_s_fs    <= w_s_fs_nxt;
            r_s_data  <= w_s_data_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign RD_EN   = r_rd_en;
    assign RD_ADDR = r_rd_addr;
    assign S_CLK   = r_s_clk;
    assign S_FS    = r_s_fs;
    assign S_DATA  = r_s_data;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign ERROR   = r_error;
endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx: per-cycle output scoreboard built from the frame timing formulas,
// a serial receiver on S_CLK falling edges, and a small-parameter second instance.
module tb_ser_tx;
    localparam int NC  = 8;
    localparam int WW  = 8;
    localparam int CD  = 4;
    localparam int CHW = 3;
    localparam int FL  = NC * WW * CD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ser_tx_if #(.NUM_CH(NC), .WORD_W(WW)) bus ();
    ser_tx_if #(.NUM_CH(2), .WORD_W(4)) bus2 ();

    ser_tx #(.NUM_CH(NC), .WORD_W(WW), .CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .START(bus.START), .RD_DATA(bus.RD_DATA),
        .RD_EN(bus.RD_EN), .RD_ADDR(bus.RD_ADDR), .S_CLK(bus.S_CLK), .S_FS(bus.S_FS),
        .S_DATA(bus.S_DATA), .BUSY(bus.BUSY), .DONE(bus.DONE), .ERROR(bus.ERROR)
    );

    ser_tx #(.NUM_CH(2), .WORD_W(4), .CLK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .START(bus2.START), .RD_DATA(bus2.RD_DATA),
        .RD_EN(bus2.RD_EN), .RD_ADDR(bus2.RD_ADDR), .S_CLK(bus2.S_CLK), .S_FS(bus2.S_FS),
        .S_DATA(bus2.S_DATA), .BUSY(bus2.BUSY), .DONE(bus2.DONE), .ERROR(bus2.ERROR)
    );

    // Buffer models: data valid only in the cycle after RD_EN, noise otherwise.
    logic [7:0] mem [NC];
    logic [3:0] mem2 [2];
    always @(posedge clk) bus.RD_DATA <= bus.RD_EN ? mem[bus.RD_ADDR] : 8'($urandom);
    always @(posedge clk) bus2.RD_DATA <= bus2.RD_EN ? mem2[bus2.RD_ADDR] : 4'($urandom);

    typedef struct {
        int             cyc;
        logic           rd_en;
        logic [CHW-1:0] addr;
        logic           chk_addr;
        logic           sclk;
        logic           fs;
        logic           sdata;
        logic           busy;
        logic           done;
    } exp_t;

    typedef struct {
        logic [63:0] words;
        int          poke;
        logic [63:0] exp_words;
    } vec_t;

    exp_t q[$];
    int   eq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    logic        prev_sclk = 1'b0, prev_sclk2 = 1'b0;
    logic [63:0] rx_sr = '0;
    int          rx_n = 0;
    logic [7:0]  rx2_sr = '0;
    int          rx2_n = 0;
    int          rden2 = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic void push_frame(input int c0);
        exp_t e;
        int idx, ch, b, ph;
        logic [7:0] w;
        for (int t = 0; t < FL + 3; t++) begin
            e.cyc = c0 + t; e.rd_en = 1'b0; e.addr = '0; e.chk_addr = 1'b0;
            e.sclk = 1'b0; e.fs = 1'b0; e.sdata = 1'b0; e.busy = 1'b0; e.done = 1'b0;
            if (t == 0) begin
                e.rd_en = 1'b1; e.chk_addr = 1'b1; e.busy = 1'b1;
            end else if (t == 1) begin
                e.busy = 1'b1;
            end else if (t < FL + 2) begin
                idx = t - 2;
                ch  = idx / (WW * CD);
                b   = (idx / CD) % WW;
                ph  = idx % CD;
                w   = mem[ch];
                e.busy  = 1'b1;
                e.sclk  = (ph < CD / 2);
                e.sdata = w[WW-1-b];
                e.fs    = (ch == 0) && (b == 0);
                if ((b == WW - 1) && (ph == 0) && (ch < NC - 1)) begin
                    e.rd_en = 1'b1; e.chk_addr = 1'b1; e.addr = CHW'(ch + 1);
                end
            end else begin
                e.done = 1'b1; e.chk_addr = 1'b1;
            end
            q.push_back(e);
        end
    endfunction

    function automatic void monitor();
        exp_t e;
        logic exp_err;
        e.cyc = cyc; e.rd_en = 1'b0; e.addr = '0; e.chk_addr = 1'b1;
        e.sclk = 1'b0; e.fs = 1'b0; e.sdata = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("sb_order", 64'(q[0].cyc), 64'(cyc));
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
        chk($sformatf("out@%0d{en,sclk,fs,sd,busy,done}", cyc),
            {bus.RD_EN, bus.S_CLK, bus.S_FS, bus.S_DATA, bus.BUSY, bus.DONE},
            {e.rd_en, e.sclk, e.fs, e.sdata, e.busy, e.done});
        if (e.chk_addr) chk($sformatf("addr@%0d", cyc), bus.RD_ADDR, e.addr);
        exp_err = (eq.size() > 0 && eq[0] == cyc);
        if (exp_err) void'(eq.pop_front());
        chk($sformatf("error@%0d", cyc), bus.ERROR, exp_err);
        if (prev_sclk && !bus.S_CLK) begin
            rx_sr = {rx_sr[62:0], bus.S_DATA};
            rx_n++;
        end
        prev_sclk = bus.S_CLK;
        if (prev_sclk2 && !bus2.S_CLK) begin
            rx2_sr = {rx2_sr[6:0], bus2.S_DATA};
            rx2_n++;
        end
        prev_sclk2 = bus2.S_CLK;
        if (bus2.RD_EN) rden2++;
    endfunction

    task automatic step();
        @(negedge clk);
        if (mon_en) monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic load_mem(input logic [63:0] words);
        for (int i = 0; i < NC; i++) mem[i] = words[63-8*i -: 8];
    endtask

    task automatic check_rx(input string tag, input logic [63:0] expw);
        chk({tag, "_bits"}, 64'(rx_n), 64'd64);
        for (int i = 0; i < NC; i++)
            chk($sformatf("%s_ch%0d", tag, i), rx_sr[63-8*i -: 8], expw[63-8*i -: 8]);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int c;
        load_mem(v.words);
        rx_sr = '0; rx_n = 0;
        c = cyc;
        bus.START = 1'b1;
        push_frame(c + 1);
        step();
        bus.START = 1'b0;
        for (int k = 1; k < FL + 4; k++) begin
            if (k == v.poke) begin
                bus.START = 1'b1;
                eq.push_back(cyc + 1);
            end
            step();
            bus.START = 1'b0;
        end
        check_rx(tag, v.exp_words);
    endtask

    vec_t tbl [5];

    initial begin
        int c, done_at;
        tbl[0] = '{64'hA501_80FF_003C_7EC3, -1,  64'hA501_80FF_003C_7EC3};
        tbl[1] = '{64'hA501_80FF_003C_7EC3, 50,  64'hA501_80FF_003C_7EC3};
        tbl[2] = '{64'h0000_0000_0000_0000, -1,  64'h0000_0000_0000_0000};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 200, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[4] = '{64'h0123_4567_89AB_CDEF, 1,   64'h0123_4567_89AB_CDEF};
        mem2[0] = 4'h9;
        mem2[1] = 4'h6;
        bus.START = 1'b0;
        bus2.START = 1'b0;
        load_mem(64'h0);
        reset = 1'b1;
        repeat (3) step();

        chk("reset_dut", {bus.RD_EN, bus.RD_ADDR, bus.S_CLK, bus.S_FS, bus.S_DATA,
                          bus.BUSY, bus.DONE, bus.ERROR}, '0);
        chk("reset_dut2", {bus2.RD_EN, bus2.RD_ADDR, bus2.S_CLK, bus2.S_FS, bus2.S_DATA,
                           bus2.BUSY, bus2.DONE, bus2.ERROR}, '0);
        mon_en = 1'b1;
        reset = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i], $sformatf("vec%0d", i));
            repeat (2) step();
        end

        // Back-to-back: second START lands in the END cycle of the first frame.
        load_mem(64'h1122_3344_5566_7788);
        rx_sr = '0; rx_n = 0;
        c = cyc;
        bus.START = 1'b1;
        push_frame(c + 1);
        step();
        bus.START = 1'b0;
        for (int k = 0; k < FL + 4 && cyc < c + FL + 3; k++) step();
        chk("b2b_end_cycle", 64'(cyc), 64'(c + FL + 3));
        check_rx("b2b_a", 64'h1122_3344_5566_7788);
        rx_sr = '0; rx_n = 0;
        bus.START = 1'b1;
        push_frame(cyc + 1);
        step();
        bus.START = 1'b0;
        for (int k = 1; k < FL + 4; k++) step();
        check_rx("b2b_b", 64'h1122_3344_5566_7788);

        // Reset during channel 3, with START held alongside it.
        load_mem(64'hDEAD_BEEF_CAFE_F00D);
        c = cyc;
        bus.START = 1'b1;
        push_frame(c + 1);
        step();
        bus.START = 1'b0;
        for (int k = 0; k < FL && cyc < c + 3 + 100; k++) step();
        reset = 1'b1;
        bus.START = 1'b1;
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        step();
        reset = 1'b0;
        bus.START = 1'b0;
        repeat (300) step();
        run_frame('{64'hDEAD_BEEF_CAFE_F00D, -1, 64'hDEAD_BEEF_CAFE_F00D}, "post_rst");
        repeat (2) step();

        // Small configuration: 2 channels x 4 bits, 2 clocks per bit.
        rx2_sr = '0; rx2_n = 0; rden2 = 0;
        c = cyc;
        done_at = -1;
        bus2.START = 1'b1;
        step();
        bus2.START = 1'b0;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            step();
            if (bus2.DONE) done_at = cyc;
        end
        chk("small_done_cycle", 64'(done_at), 64'(c + 19));
        chk("small_busy_at_done", bus2.BUSY, 1'b0);
        chk("small_rden_count", 64'(rden2), 64'd2);
        chk("small_bits", 64'(rx2_n), 64'd8);
        chk("small_words", rx2_sr, 8'h96);
        step();
        chk("small_done_pulse", {bus2.DONE, bus2.BUSY}, 2'b00);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: channels per frame; CH_W = clog2(NUM_CH).
REQ-002 SHALL have parameter WORD_W, default 8: bits per channel word.
REQ-003 SHALL have parameter CLK_DIV, default 4: clk cycles per serial bit; even, >= 2.
REQ-004 SHALL have port clk  input  1: single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port START  input  1: one-cycle frame-start request, typically from the control unit after FA_DONE.
REQ-007 SHALL have port RD_DATA  input  WORD_W: buffer read data, valid one clk after RD_EN.
REQ-008 SHALL have port RD_EN  output  1: buffer read strobe.
REQ-009 SHALL have port RD_ADDR  output  CH_W: buffer read address, the channel being fetched.
REQ-010 SHALL have port S_CLK  output  1: generated serial bit clock.
REQ-011 SHALL have port S_FS  output  1: serial frame sync.
REQ-012 SHALL have port S_DATA  output  1: serial data, MSB first.
REQ-013 SHALL have port BUSY  output  1: frame in progress.
REQ-014 SHALL have port DONE  output  1: one-cycle end-of-frame pulse.
REQ-015 SHALL have port ERROR  output  1: one-cycle pulse on rejected START.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States SHALL be IDLE, FETCH, LOAD, SHIFT, END.
- IDLE: BUSY=0; START=1 -> FETCH.
- FETCH (1 cycle): RD_EN=1, RD_ADDR=0 -> LOAD.
- LOAD (1 cycle): RD_DATA captured into shift register -> SHIFT.
- SHIFT: one bit period per CLK_DIV cycles, WORD_W bits per word, NUM_CH words per frame; after last bit of channel NUM_CH-1 -> END.
- END (1 cycle): DONE=1, BUSY=0 -> IDLE.
REQ-018 BUSY SHALL be 1 in FETCH, LOAD, SHIFT and 0 in IDLE, END.
REQ-019 Latency: START sampled at edge N -> RD_EN high in cycle N+1 -> first bit on S_DATA in cycle N+3.
REQ-020 Within each bit period, S_CLK SHALL be 1 for the first CLK_DIV/2 cycles and 0 for the remainder; S_DATA SHALL hold constant for the whole period, so the receiver samples on the S_CLK falling edge.
REQ-021 S_FS SHALL be 1 for exactly the first bit period of channel 0 and 0 at all other times.
REQ-022 Prefetch: in the first cycle of the last bit period of channel k < NUM_CH-1, the block SHALL assert RD_EN for one cycle with RD_ADDR=k+1; RD_DATA SHALL be held next cycle and loaded into the shifter at the word boundary.
- Bit stream SHALL be continuous across words, with no gap cycles.
REQ-023 Frame length SHALL be NUM_CH*WORD_W*CLK_DIV SHIFT cycles (default 256); RD_EN SHALL pulse exactly NUM_CH times per frame.
REQ-024 Channel counter SHALL not wrap within a frame; RD_ADDR SHALL return to 0 in END.
REQ-025 START while BUSY=1 SHALL be ignored with ERROR=1 for one cycle; the frame in progress is unaffected.
REQ-026 START sampled in END SHALL be accepted: FETCH next cycle, back-to-back frames.
REQ-027 In IDLE and END: S_CLK=0, S_DATA=0, S_FS=0.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE and set RD_EN, RD_ADDR, S_CLK, S_FS, S_DATA, BUSY, DONE, ERROR, counters and shifter to 0 by that edge, from any state.
REQ-029 reset SHALL take priority over START.
REQ-030 After reset mid-frame, no further RD_EN SHALL occur until a new START.

Verification
REQ-031 Basic frame (defaults): buffer ch0..7 = 0xA5,0x01,0x80,0xFF,0x00,0x3C,0x7E,0xC3; START pulse -> RD_EN at +1 with addr 0; S_DATA from +3 = 10100101 00000001 ...; S_FS high 4 cycles; DONE 256 cycles after first bit; BUSY low after.
REQ-032 S_CLK timing -> every bit period is 1100; S_DATA changes only on S_CLK rising edges; receiver captures all 8 words intact.
REQ-033 START at cycle 50 of a frame -> ERROR one cycle; output stream bit-identical to REQ-031.
REQ-034 START coincident with DONE -> second frame's first bit 3 cycles after END; S_FS asserted again.
REQ-035 reset asserted during channel 3 -> all outputs 0 next cycle; no RD_EN until new START; new frame restarts at channel 0.
REQ-036 NUM_CH=2, WORD_W=4, CLK_DIV=2 -> 16-cycle frame; exactly 2 RD_EN pulses.
